// File: rtl/adc_ctrl_pkg.sv
// Shared types and constants for the ADC capture controller.
// Holds the FSM state encoding, the status word bit positions and the reset decimation ratio.
package adc_ctrl_pkg;

    // Encoding is exported in status[31:30], so the values are fixed.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        STOP    = 2'd3
    } state_t;

    localparam int STATUS_STATE_HI = 31;
    localparam int STATUS_STATE_LO = 30;
    localparam int STATUS_OVERFLOW = 29;
    localparam int STATUS_ABORTED  = 28;

    localparam logic [15:0] DEFAULT_DECIMATE = 16'd40;

endpackage

// File: rtl/axis_skid_reg.sv
// One-entry AXI-Stream output register.
// A word arriving while the entry is full and not draining is dropped and flagged.
module axis_skid_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    input  logic              force_last,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              accept,
    output logic              drop
);

    assign accept = s_valid && (!m_valid || m_ready);
    assign drop   = s_valid && m_valid && !m_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (accept) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            m_last  <= s_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (force_last && m_valid) begin
            // Held word stays put; only its end-of-packet marker changes.
            m_last <= 1'b1;
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Sequences one ADC receive capture: configure the chain, let the filters flush,
// then forward a programmed number of decimated I/Q words to the DMA with tlast on the final one.
module adc_capture_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int CNT_W         = 24,
    parameter int SETTLE_CYCLES = 512
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cmd_start,
    input  logic              cmd_abort,
    input  logic [31:0]       cfg_fc_scaled,
    input  logic [15:0]       cfg_decimate,
    input  logic [CNT_W-1:0]  cfg_num_samples,
    output logic [31:0]       Fc_scaled,
    output logic [15:0]       decimate_ratio,
    output logic [3:0]        adc_control,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done,
    output logic [31:0]       status
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    state_t              state;
    logic [CNT_W-1:0]    target;
    logic [CNT_W-1:0]    accepted_cnt;
    logic [CNT_W-1:0]    delivered_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                adc_en;
    logic                overflow;
    logic                aborted;

    logic skid_in_valid;
    logic skid_in_last;
    logic skid_force_last;
    logic skid_accept;
    logic skid_drop;
    logic handshake;

    // Inputs are taken only while capturing, and never on the cycle an abort arrives.
    assign skid_in_valid   = (state == CAPTURE) && s_axis_tvalid && !cmd_abort;
    assign skid_in_last    = (accepted_cnt == target - CNT_W'(1));
    assign skid_force_last = (state == CAPTURE) && cmd_abort;
    assign handshake       = m_axis_tvalid && m_axis_tready;

    axis_skid_reg #(
        .DATA_W(DATA_W)
    ) u_out_reg (
        .clk       (aclk),
        .rst       (areset),
        .s_data    (s_axis_tdata),
        .s_valid   (skid_in_valid),
        .s_last    (skid_in_last),
        .force_last(skid_force_last),
        .m_data    (m_axis_tdata),
        .m_valid   (m_axis_tvalid),
        .m_last    (m_axis_tlast),
        .m_ready   (m_axis_tready),
        .accept    (skid_accept),
        .drop      (skid_drop)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            state          <= IDLE;
            Fc_scaled      <= '0;
            decimate_ratio <= DEFAULT_DECIMATE;
            adc_en         <= 1'b0;
            done           <= 1'b0;
            target         <= '0;
            accepted_cnt   <= '0;
            delivered_cnt  <= '0;
            settle_cnt     <= '0;
            overflow       <= 1'b0;
            aborted        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (handshake)   delivered_cnt <= delivered_cnt + CNT_W'(1);
            if (skid_accept) accepted_cnt  <= accepted_cnt + CNT_W'(1);
            if (skid_drop)   overflow      <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (cmd_start && cfg_num_samples != '0) begin
                        Fc_scaled      <= cfg_fc_scaled;
                        decimate_ratio <= cfg_decimate;
                        target         <= cfg_num_samples;
                        accepted_cnt   <= '0;
                        delivered_cnt  <= '0;
                        settle_cnt     <= '0;
                        overflow       <= 1'b0;
                        aborted        <= 1'b0;
                        adc_en         <= 1'b1;
                        state          <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cmd_abort) begin
                        aborted <= 1'b1;
                        adc_en  <= 1'b0;
                        state   <= STOP;
                    end else if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        state <= CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end
                CAPTURE: begin
                    if (cmd_abort) begin
                        aborted <= 1'b1;
                        adc_en  <= 1'b0;
                        state   <= STOP;
                    end else if (skid_accept && skid_in_last) begin
                        adc_en <= 1'b0;
                        state  <= STOP;
                    end
                end
                STOP: begin
                    // An abort with nothing pending finishes straight away.
                    if (!m_axis_tvalid || handshake) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign adc_control   = {3'b000, adc_en};
    assign s_axis_tready = 1'b1;
    assign busy          = (state != IDLE);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        status                                   = '0;
        status[STATUS_STATE_HI:STATUS_STATE_LO]  = state;
        status[STATUS_OVERFLOW]                  = overflow;
        status[STATUS_ABORTED]                   = aborted;
        status[CNT_W-1:0]                        = delivered_cnt;
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: stimulus queues expected words, a negedge monitor
// pops and compares them on every output handshake.
module tb_adc_capture_ctrl;

    localparam int DATA_W        = 32;
    localparam int CNT_W         = 24;
    localparam int SETTLE_CYCLES = 512;

    logic              aclk            = 1'b0;
    logic              areset          = 1'b1;
    logic              cmd_start       = 1'b0;
    logic              cmd_abort       = 1'b0;
    logic [31:0]       cfg_fc_scaled   = '0;
    logic [15:0]       cfg_decimate    = '0;
    logic [CNT_W-1:0]  cfg_num_samples = '0;
    logic [31:0]       Fc_scaled;
    logic [15:0]       decimate_ratio;
    logic [3:0]        adc_control;
    logic [DATA_W-1:0] s_axis_tdata    = '0;
    logic              s_axis_tvalid   = 1'b0;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready   = 1'b0;
    logic              m_axis_tlast;
    logic              busy;
    logic              done;
    logic [31:0]       status;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t exp_q[$];
    int    checks      = 0;
    int    errors      = 0;
    int    done_pulses = 0;

    adc_capture_ctrl #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .aclk(aclk), .areset(areset), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cfg_fc_scaled(cfg_fc_scaled), .cfg_decimate(cfg_decimate),
        .cfg_num_samples(cfg_num_samples), .Fc_scaled(Fc_scaled),
        .decimate_ratio(decimate_ratio), .adc_control(adc_control),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done), .status(status)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: a word counts as delivered when valid and ready are both high before the edge.
    always @(negedge aclk) begin
        beat_t e;
        if (done === 1'b1) done_pulses++;
        if (areset === 1'b0 && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%08h last=%0b, expected no word",
                         m_axis_tdata, m_axis_tlast);
            end else begin
                e = exp_q.pop_front();
                check("m_tdata", m_axis_tdata, e.data);
                check("m_tlast", 32'(m_axis_tlast), 32'(e.last));
            end
        end
    end

    initial begin
        repeat (50000) @(posedge aclk);
        $display("FAIL watchdog: simulation exceeded 50000 cycles, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic start(input logic [31:0] fc, input logic [15:0] dec, input logic [CNT_W-1:0] num);
        cfg_fc_scaled   = fc;
        cfg_decimate    = dec;
        cfg_num_samples = num;
        cmd_start       = 1'b1;
        tick();
        cmd_start       = 1'b0;
    endtask

    // Drives junk words for the whole settle window; none may reach the output.
    task automatic settle(input string name);
        bit any_v = 1'b0;
        for (int i = 0; i < SETTLE_CYCLES; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'hDEAD_0000 + 32'(i);
            tick();
            if (m_axis_tvalid !== 1'b0) any_v = 1'b1;
        end
        check({name, "_settle_no_valid"}, 32'(any_v), 32'd0);
        check({name, "_state_capture"}, 32'(status[31:30]), 32'd2);
    endtask

    task automatic feed(input logic [31:0] data, input logic last, input bit push);
        beat_t b;
        b.data = data;
        b.last = last;
        if (push) exp_q.push_back(b);
        s_axis_tdata  = data;
        s_axis_tvalid = 1'b1;
        tick();
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic junk_input();
        s_axis_tdata  = 32'hBAD0_BAD0;
        s_axis_tvalid = 1'b1;
    endtask

    initial begin
        int d0;
        int n;

        // Reset values.
        areset        = 1'b1;
        m_axis_tready = 1'b1;
        repeat (2) tick();
        check("rst_fc", Fc_scaled, 32'd0);
        check("rst_dec", 32'(decimate_ratio), 32'd40);
        check("rst_adc", 32'(adc_control), 32'd0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_status", status, 32'd0);
        check("rst_tready", 32'(s_axis_tready), 32'd1);
        areset = 1'b0;
        tick();

        // Normal 8-word capture with the DMA always ready.
        d0 = done_pulses;
        start(32'd10737418, 16'd160, 24'd8);
        check("t1_adc_on", 32'(adc_control), 32'd1);
        check("t1_fc", Fc_scaled, 32'd10737418);
        check("t1_dec", 32'(decimate_ratio), 32'd160);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_state_settle", 32'(status[31:30]), 32'd1);
        settle("t1");
        for (int k = 0; k < 8; k++) feed(32'h1000_0100 + 32'(k) * 32'h0001_0001, k == 7, 1'b1);
        junk_input();
        check("t1_adc_off_stop", 32'(adc_control), 32'd0);
        wait_done("t1_done", 4);
        repeat (3) tick();
        check("t1_done_once", 32'(done_pulses - d0), 32'd1);
        check("t1_count", 32'(status[23:0]), 32'd8);
        check("t1_overflow", 32'(status[29]), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // Downstream stall of 20 cycles with input valid every cycle.
        d0 = done_pulses;
        start(32'd10737418, 16'd160, 24'd8);
        settle("t2");
        m_axis_tready = 1'b0;
        for (int k = 0; k < 20; k++) feed(32'h2000_0000 + 32'(k), 1'b0, k == 0);
        check("t2_held_word", m_axis_tdata, 32'h2000_0000);
        check("t2_held_valid", 32'(m_axis_tvalid), 32'd1);
        check("t2_overflow_set", 32'(status[29]), 32'd1);
        m_axis_tready = 1'b1;
        for (int k = 20; k < 27; k++) feed(32'h2000_0000 + 32'(k), k == 26, 1'b1);
        junk_input();
        wait_done("t2_done", 4);
        repeat (3) tick();
        check("t2_done_once", 32'(done_pulses - d0), 32'd1);
        check("t2_count", 32'(status[23:0]), 32'd8);
        check("t2_overflow", 32'(status[29]), 32'd1);

        // Abort during SETTLE.
        d0 = done_pulses;
        start(32'h0055_0000, 16'd64, 24'd8);
        junk_input();
        repeat (100) tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        check("t3_adc_off", 32'(adc_control), 32'd0);
        check("t3_state_stop", 32'(status[31:30]), 32'd3);
        wait_done("t3_done", 2);
        repeat (3) tick();
        check("t3_done_once", 32'(done_pulses - d0), 32'd1);
        check("t3_count", 32'(status[23:0]), 32'd0);
        check("t3_aborted", 32'(status[28]), 32'd1);
        check("t3_idle", 32'(busy), 32'd0);

        // Abort in CAPTURE with the 4th word pending.
        d0 = done_pulses;
        start(32'h0077_7777, 16'd20, 24'd8);
        settle("t4");
        for (int k = 0; k < 4; k++) feed(32'h4000_0000 + 32'(k), k == 3, 1'b1);
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
        cmd_abort     = 1'b1;
        tick();
        cmd_abort     = 1'b0;
        check("t4_forced_last", 32'(m_axis_tlast), 32'd1);
        check("t4_pending_word", m_axis_tdata, 32'h4000_0003);
        check("t4_count_before", 32'(status[23:0]), 32'd3);
        check("t4_adc_off", 32'(adc_control), 32'd0);
        m_axis_tready = 1'b1;
        wait_done("t4_done", 4);
        repeat (3) tick();
        check("t4_done_once", 32'(done_pulses - d0), 32'd1);
        check("t4_count", 32'(status[23:0]), 32'd4);
        check("t4_aborted", 32'(status[28]), 32'd1);

        // Illegal start (num=0) and start while busy.
        d0 = done_pulses;
        start(32'h1234_5678, 16'd7, 24'd0);
        check("t5_zero_busy", 32'(busy), 32'd0);
        check("t5_zero_fc", Fc_scaled, 32'h0077_7777);
        check("t5_zero_dec", 32'(decimate_ratio), 32'd20);
        repeat (3) tick();
        check("t5_zero_no_done", 32'(done_pulses - d0), 32'd0);
        start(32'h0100_0000, 16'd80, 24'd4);
        repeat (10) tick();
        start(32'h0BAD_0BAD, 16'd3, 24'd5);
        check("t5_busy_fc", Fc_scaled, 32'h0100_0000);
        check("t5_busy_dec", 32'(decimate_ratio), 32'd80);
        check("t5_busy_state", 32'(status[31:30]), 32'd1);

        // areset in CAPTURE abandons the partial packet.
        n = 0;
        s_axis_tvalid = 1'b0;
        while (status[31:30] !== 2'd2 && n < 600) begin
            tick();
            n++;
        end
        check("t6_reach_capture", 32'(status[31:30]), 32'd2);
        feed(32'h6000_0000, 1'b0, 1'b1);
        feed(32'h6000_0001, 1'b0, 1'b0);
        areset        = 1'b1;
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
        tick();
        check("t6_rst_fc", Fc_scaled, 32'd0);
        check("t6_rst_dec", 32'(decimate_ratio), 32'd40);
        check("t6_rst_adc", 32'(adc_control), 32'd0);
        check("t6_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t6_rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_status", status, 32'd0);
        areset        = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        start(32'h0000_ABCD, 16'd40, 24'd2);
        settle("t6");
        feed(32'h6100_0000, 1'b0, 1'b1);
        feed(32'h6100_0001, 1'b1, 1'b1);
        junk_input();
        wait_done("t6_done", 4);
        repeat (3) tick();
        check("t6_done_once", 32'(done_pulses - d0), 32'd1);
        check("t6_count", 32'(status[23:0]), 32'd2);
        check("t6_aborted", 32'(status[28]), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Sequences one ADC receive capture through the ADC chain (mixer, DDC, decimator) in the 100 MHz aclk domain.
- Latches a capture command and drives the chain's Fc_scaled, decimate_ratio and ADC_control configuration.
- Waits a fixed settle time, then gates a programmed number of decimated I/Q words from the chain's AXI-Stream output to the downstream DMA and marks the last one with tlast.
- Sits between the PS register block and ADC_Chain_wrapper.

Parameters:
DATA_W, 32, width of the I/Q stream word (Q in [31:16], I in [15:0])
CNT_W, 24, width of the sample counter and the cfg_num_samples port
SETTLE_CYCLES, 512, aclk cycles between enabling the ADC and accepting the first sample (filter and DDC flush)

Ports:
aclk  in  1  system clock, 100 MHz
areset  in  1  synchronous, active-high reset
cmd_start  in  1  one-cycle pulse; starts a capture when in IDLE
cmd_abort  in  1  one-cycle pulse; terminates the capture in any non-IDLE state
cfg_fc_scaled  in  32  carrier phase increment; sampled on an accepted cmd_start
cfg_decimate  in  16  decimation ratio; sampled on an accepted cmd_start
cfg_num_samples  in  CNT_W  number of output words to capture; 0 is illegal (see Behaviour)
Fc_scaled  out  32  to ADC chain
decimate_ratio  out  16  to ADC chain
adc_control  out  4  to ADC chain; bit0 is the ADC enable, bits[3:1] are always 0
s_axis_tdata  in  DATA_W  from ADC chain
s_axis_tvalid  in  1  from ADC chain
s_axis_tready  out  1  to ADC chain; constant 1 (the chain cannot stall)
m_axis_tdata  out  DATA_W  to DMA
m_axis_tvalid  out  1  to DMA
m_axis_tready  in  1  from DMA
m_axis_tlast  out  1  asserted on the final captured word
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at the end of a capture, normal or aborted
status  out  32  [31:30]=state, [29]=overflow, [28]=aborted, [CNT_W-1:0]=words delivered

Behaviour:
- Reset values (areset=1, synchronous): state IDLE, Fc_scaled 0, decimate_ratio 16'd40, adc_control 0, m_axis_tvalid 0, m_axis_tlast 0, busy 0, done 0, all counters 0, all sticky flags 0.
- States are IDLE(0), SETTLE(1), CAPTURE(2), STOP(3), encoded into status[31:30].
- IDLE:
  - cmd_start with cfg_num_samples != 0: latch cfg_* into Fc_scaled, decimate_ratio and the target count; clear counters and sticky flags; set adc_control[0]=1; go to SETTLE on the next edge.
  - cmd_start with cfg_num_samples == 0: ignored; done stays 0.
- SETTLE:
  - Counter runs from 0 to SETTLE_CYCLES-1, then the state goes to CAPTURE.
  - Incoming stream words are discarded (s_axis_tready=1, m_axis_tvalid=0).
- CAPTURE, output register:
  - Single output register stage; latency from input to output is 1 cycle.
  - On s_axis_tvalid, if the register is empty or m_axis_tready=1, load tdata, set m_axis_tvalid=1, and increment the accepted count.
  - If the register is full and m_axis_tready=0, drop the word and set sticky overflow. The held word is not modified.
- CAPTURE, count and tlast:
  - m_axis_tlast=1 with the word whose accepted count equals the target.
  - After that word is loaded, no further inputs are accepted (they are discarded) and the state goes to STOP.
- STOP:
  - adc_control[0]=0 immediately on entry.
  - Hold m_axis_tvalid/tlast until m_axis_tready; on the handshake, pulse done and go to IDLE.
- Delivered count increments on each m_axis handshake and is exposed in status.
- cmd_abort in SETTLE or CAPTURE:
  - Set the aborted flag and adc_control[0]=0, and go to STOP.
  - In STOP, if a word is pending, force tlast=1 on it and complete the handshake. If no word is pending, pulse done on the cycle after entry.
- cmd_abort in IDLE or STOP is ignored. cmd_start while busy is ignored.
- cmd_start and cmd_abort in the same IDLE cycle: the start wins and the abort is ignored.
- Fc_scaled and decimate_ratio hold their values after a capture ends, until the next accepted start.
- Counter widths: the accepted and delivered counters are CNT_W bits and never wrap, because the target is at most 2^CNT_W-1.
- areset mid-capture returns every output to its reset value on the next edge. A partial packet is abandoned with no tlast.

Decomposition:
- Package adc_ctrl_pkg holds:
  - state_t enum (IDLE, SETTLE, CAPTURE, STOP) with a 2-bit encoding;
  - STATUS_* bit-position constants;
  - DEFAULT_DECIMATE = 16'd40.
- Sub-module axis_skid_reg: the 1-entry output register with a drop/overflow indication. Instantiated once.

Test Plan:
- Reset, then start with fc=10737418, decimate=160, num=8, m_tready=1:
  - adc_control=1 one cycle after the start;
  - no m_tvalid for 512 cycles;
  - 8 words out in input order, tlast only on the 8th;
  - done pulses once; status count=8, overflow=0.
- Same capture with m_tready held 0 for 20 cycles while input is valid every cycle: overflow=1, the held word is unchanged, and tlast still falls on the 8th delivered word.
- Abort during SETTLE at cycle 100: adc_control drops the next cycle, zero words delivered, done pulses within 2 cycles, aborted=1.
- Abort mid-CAPTURE after 3 words with one word pending: 4th word carries tlast=1, status count=4, aborted=1.
- Start with num=0, and start while busy: no state change and no done; latched config is unchanged.
- areset asserted during CAPTURE: all outputs match reset values one cycle later; a subsequent start with num=2 completes normally.
